// File: rtl/bcd_defs.sv
// Shared BCD constants for the up/down counter and its per-digit cells.
package bcd_defs;
  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_MIN_DIGIT = 4'd0;
endpackage

// File: rtl/bcd_updown_digit.sv
// One BCD digit cell: clamped load, increment/decrement with 9<->0 rollover,
// and a terminal flag used to build the carry/borrow chain.
module bcd_updown_digit
  import bcd_defs::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  input  logic                   up,
  input  logic                   load,
  input  logic [BCD_DIGIT_W-1:0] load_digit,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   term
);

  logic [BCD_DIGIT_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = (load_digit > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : load_digit;
    end else if (step) begin
      if (up) digit_d = (digit_q == BCD_MAX_DIGIT) ? BCD_MIN_DIGIT : digit_q + 4'd1;
      else    digit_d = (digit_q == BCD_MIN_DIGIT) ? BCD_MAX_DIGIT : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) digit_q <= BCD_MIN_DIGIT;
    else      digit_q <= digit_d;
  end

  assign digit = digit_q;
  assign term  = up ? (digit_q == BCD_MAX_DIGIT) : (digit_q == BCD_MIN_DIGIT);

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with load, wrap pulse, sticky ovf and eos.
// Optional tick prescaler is compiled in with `define TICK_PRESCALER_EN.
module bcd_updown_counter
  import bcd_defs::*;
#(
  parameter int          NDIGIT   = 4,
  parameter int unsigned TICK_MAX = 100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          up,
  input  logic                          load,
  input  logic [BCD_DIGIT_W*NDIGIT-1:0] load_val,
  input  logic                          clear_ovf,
  output logic [BCD_DIGIT_W*NDIGIT-1:0] bcd,
  output logic                          eos,
  output logic                          wrap,
  output logic                          ovf
);

  if (NDIGIT < 1 || NDIGIT > 8) begin : g_bad_ndigit
    $error("bcd_updown_counter: NDIGIT must be 1..8");
  end
  if (TICK_MAX == 0) begin : g_bad_tick_max
    $error("bcd_updown_counter: TICK_MAX must be at least 1");
  end

  logic              tick;
  logic              step;
  logic [NDIGIT-1:0] term;
  logic [NDIGIT:0]   chain;
  logic              wrap_q, wrap_d;
  logic              ovf_q, ovf_d;

`ifdef TICK_PRESCALER_EN
  logic [31:0] pcnt_q, pcnt_d;

  // Free-running: load and en do not restart or hold the prescaler.
  assign tick = (pcnt_q == TICK_MAX - 32'd1);

  always_comb begin
    pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) pcnt_q <= 32'd0;
    else      pcnt_q <= pcnt_d;
  end
`else
  assign tick = 1'b1;
`endif

  assign step = en & tick;

  // chain[k] is high when every digit below k is at its terminal value.
  always_comb begin
    chain    = '0;
    chain[0] = 1'b1;
    for (int i = 0; i < NDIGIT; i++) chain[i+1] = chain[i] & term[i];
  end

  for (genvar k = 0; k < NDIGIT; k++) begin : g_digit
    bcd_updown_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .step       (step & chain[k]),
      .up         (up),
      .load       (load),
      .load_digit (load_val[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .digit      (bcd[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .term       (term[k])
    );
  end

  always_comb begin
    wrap_d = step & chain[NDIGIT] & ~load;
    ovf_d  = wrap_d | (ovf_q & ~clear_ovf);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign eos  = chain[NDIGIT];
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: 2- and 3-digit instances checked against an
// integer-arithmetic model via a scoreboard, plus hand-computed vector tables.
module tb_bcd_updown_counter;

`ifdef TICK_PRESCALER_EN
  localparam int TM = 5;
`else
  localparam int TM = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, en, up, load, clear_ovf;
  logic [7:0]  lv2, bcd2;
  logic [11:0] lv3, bcd3;
  logic        eos2, wrap2, ovf2, eos3, wrap3, ovf3;

  always #5 clk = ~clk;

  bcd_updown_counter #(.NDIGIT(2), .TICK_MAX(5)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv2),
    .clear_ovf(clear_ovf), .bcd(bcd2), .eos(eos2), .wrap(wrap2), .ovf(ovf2));

  bcd_updown_counter #(.NDIGIT(3), .TICK_MAX(5)) u3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv3),
    .clear_ovf(clear_ovf), .bcd(bcd3), .eos(eos3), .wrap(wrap3), .ovf(ovf3));

  typedef struct {
    logic [7:0]  b2; logic w2, o2, e2;
    logic [11:0] b3; logic w3, o3, e3;
  } exp_t;

  typedef struct {
    logic r, e, u, l, c;
    logic [11:0] lv;
    logic [7:0]  b2; logic w2, o2, e2;
    logic [11:0] b3; logic w3, o3, e3;
  } vec_t;

  exp_t sb[$];
  int   n_pass = 0, n_tot = 0;
  int   mv[2], mo[2];
  int   pcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic int bcd2int(input logic [11:0] v, input int nd);
    int s = 0, p = 1;
    logic [3:0] d;
    for (int k = 0; k < nd; k++) begin
      d = v[4*k +: 4];
      if (d > 4'd9) d = 4'd9;
      s = s + int'(d) * p;
      p = p * 10;
    end
    return s;
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    logic [11:0] b;
    b = '0;
    for (int k = 0; k < 3; k++) b[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return b;
  endfunction

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic apply(input logic r, e, u, l, c, input logic [11:0] lv);
    exp_t        x;
    bit          tk;
    int          m;
    bit          w[2];
    logic [11:0] tmp;
    rst = r; en = e; up = u; load = l; clear_ovf = c; lv3 = lv; lv2 = lv[7:0];
    tk   = (pcnt == TM - 1);
    pcnt = (!r || tk) ? 0 : pcnt + 1;
    for (int i = 0; i < 2; i++) begin
      m    = pow10(i + 2);
      w[i] = 1'b0;
      if (!r) begin
        mv[i] = 0; mo[i] = 0;
      end else begin
        if (l) mv[i] = bcd2int(lv, i + 2);
        else if (e && tk) begin
          if (u) begin
            if (mv[i] == m - 1) begin mv[i] = 0; w[i] = 1'b1; end
            else mv[i] = mv[i] + 1;
          end else begin
            if (mv[i] == 0) begin mv[i] = m - 1; w[i] = 1'b1; end
            else mv[i] = mv[i] - 1;
          end
        end
        if (w[i]) mo[i] = 1;
        else if (c) mo[i] = 0;
      end
    end
    tmp  = int2bcd(mv[0]);
    x.b2 = tmp[7:0];
    x.w2 = w[0]; x.o2 = (mo[0] != 0);
    x.e2 = u ? (mv[0] == 99) : (mv[0] == 0);
    x.b3 = int2bcd(mv[1]);
    x.w3 = w[1]; x.o3 = (mo[1] != 0);
    x.e3 = u ? (mv[1] == 999) : (mv[1] == 0);
    sb.push_back(x);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_tot++;
      $display("FAIL scoreboard: queue empty, got nothing expected one entry");
    end else begin
      x = sb.pop_front();
      chk("sb_bcd2", 32'(bcd2), 32'(x.b2));
      chk("sb_wrap2", 32'(wrap2), 32'(x.w2));
      chk("sb_ovf2", 32'(ovf2), 32'(x.o2));
      chk("sb_eos2", 32'(eos2), 32'(x.e2));
      chk("sb_bcd3", 32'(bcd3), 32'(x.b3));
      chk("sb_wrap3", 32'(wrap3), 32'(x.w3));
      chk("sb_ovf3", 32'(ovf3), 32'(x.o3));
      chk("sb_eos3", 32'(eos3), 32'(x.e3));
    end
  endtask

  initial begin
    vec_t vt[17];
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; clear_ovf = 1'b0;
    lv2 = '0; lv3 = '0;

    //          r  e  u  l  c  lv       b2   w o e  b3      w o e
    vt[0]  = '{1, 1, 0, 1, 0, 12'h001, 8'h01, 0,1,0, 12'h001, 0,0,0};
    vt[1]  = '{1, 1, 0, 0, 0, 12'h000, 8'h00, 0,1,1, 12'h000, 0,0,1};
    vt[2]  = '{1, 1, 0, 0, 0, 12'h000, 8'h99, 1,1,0, 12'h999, 1,1,0};
    vt[3]  = '{1, 1, 0, 0, 1, 12'h000, 8'h98, 0,0,0, 12'h998, 0,0,0};
    vt[4]  = '{1, 1, 1, 1, 0, 12'hF3C, 8'h39, 0,0,0, 12'h939, 0,0,0};
    vt[5]  = '{1, 0, 1, 1, 0, 12'hFFF, 8'h99, 0,0,1, 12'h999, 0,0,1};
    vt[6]  = '{1, 1, 1, 0, 1, 12'h000, 8'h00, 1,1,0, 12'h000, 1,1,0};
    vt[7]  = '{1, 0, 1, 0, 1, 12'h000, 8'h00, 0,0,0, 12'h000, 0,0,0};
    vt[8]  = '{1, 0, 0, 0, 0, 12'h000, 8'h00, 0,0,1, 12'h000, 0,0,1};
    vt[9]  = '{1, 1, 0, 0, 0, 12'h000, 8'h99, 1,1,0, 12'h999, 1,1,0};
    vt[10] = '{1, 0, 0, 1, 0, 12'h057, 8'h57, 0,1,0, 12'h057, 0,1,0};
    vt[11] = '{0, 1, 1, 1, 0, 12'h123, 8'h00, 0,0,0, 12'h000, 0,0,0};
    vt[12] = '{1, 1, 1, 0, 0, 12'h000, 8'h01, 0,0,0, 12'h001, 0,0,0};
    vt[13] = '{1, 1, 0, 0, 0, 12'h000, 8'h00, 0,0,1, 12'h000, 0,0,1};
    vt[14] = '{1, 1, 1, 0, 0, 12'h000, 8'h01, 0,0,0, 12'h001, 0,0,0};
    vt[15] = '{1, 0, 0, 1, 0, 12'h100, 8'h00, 0,0,1, 12'h100, 0,0,0};
    vt[16] = '{1, 1, 0, 0, 0, 12'h000, 8'h99, 1,1,0, 12'h099, 0,0,0};

    apply(0, 0, 1, 0, 0, 12'h000);
    apply(0, 0, 1, 0, 0, 12'h000);
    chk("reset_bcd3", 32'(bcd3), 32'h0);
    chk("reset_ovf3", 32'(ovf3), 32'h0);
    chk("reset_eos2", 32'(eos2), 32'h0);

`ifdef TICK_PRESCALER_EN
    for (int k = 1; k <= 15; k++) begin
      apply(1, (k != 10), 1, 0, 0, 12'h000);
      if (k == 4)  chk("psc_edge4",  32'(bcd2), 32'h00);
      if (k == 5)  chk("psc_edge5",  32'(bcd2), 32'h01);
      if (k == 9)  chk("psc_edge9",  32'(bcd2), 32'h01);
      if (k == 10) chk("psc_edge10", 32'(bcd2), 32'h01);
      if (k == 15) chk("psc_edge15", 32'(bcd2), 32'h02);
    end
    apply(1, 1, 1, 1, 0, 12'h03C);
    chk("psc_load_clamp", 32'(bcd2), 32'h39);
`else
    for (int k = 0; k < 10; k++) apply(1, 1, 1, 0, 0, 12'h000);
    chk("count10_bcd2", 32'(bcd2), 32'h10);
    for (int k = 0; k < 89; k++) apply(1, 1, 1, 0, 0, 12'h000);
    chk("count99_bcd2", 32'(bcd2), 32'h99);
    chk("count99_eos2", 32'(eos2), 32'h1);
    apply(1, 1, 1, 0, 0, 12'h000);
    chk("wrap_bcd2", 32'(bcd2), 32'h00);
    chk("wrap_pulse2", 32'(wrap2), 32'h1);
    chk("wrap_ovf2", 32'(ovf2), 32'h1);
    chk("nowrap_bcd3", 32'(bcd3), 32'h100);
    apply(1, 1, 1, 0, 0, 12'h000);
    chk("wrap_end2", 32'(wrap2), 32'h0);
    chk("count101_bcd3", 32'(bcd3), 32'h101);

    for (int i = 0; i < 17; i++) begin
      apply(vt[i].r, vt[i].e, vt[i].u, vt[i].l, vt[i].c, vt[i].lv);
      chk($sformatf("vec%0d_bcd2", i), 32'(bcd2), 32'(vt[i].b2));
      chk($sformatf("vec%0d_wrap2", i), 32'(wrap2), 32'(vt[i].w2));
      chk($sformatf("vec%0d_ovf2", i), 32'(ovf2), 32'(vt[i].o2));
      chk($sformatf("vec%0d_eos2", i), 32'(eos2), 32'(vt[i].e2));
      chk($sformatf("vec%0d_bcd3", i), 32'(bcd3), 32'(vt[i].b3));
      chk($sformatf("vec%0d_wrap3", i), 32'(wrap3), 32'(vt[i].w3));
      chk($sformatf("vec%0d_ovf3", i), 32'(ovf3), 32'(vt[i].o3));
      chk($sformatf("vec%0d_eos3", i), 32'(eos3), 32'(vt[i].e3));
    end
`endif

    for (int k = 0; k < 400; k++) begin
      logic [11:0] rv;
      case ($urandom_range(0, 3))
        0:       rv = 12'h999;
        1:       rv = 12'h000;
        default: rv = 12'($urandom);
      endcase
      apply(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised N-digit BCD up/down counter, the successor to the single-direction cascaded BCD counter used in the lab designs. It adds runtime count direction, synchronous parallel load, a registered wrap pulse, a sticky out-of-range flag and a direction-aware end-of-scale flag. An optional built-in tick prescaler advances the count at a reduced rate while every flip-flop stays on the single system clock. It sits between the clock/PLL domain logic and display or readout logic, such as a seven-segment multiplexer.

## Interface
- Parameters:
  - NDIGIT, default 4: number of BCD digits; legal range 1..8.
  - TICK_MAX, default 100: prescaler period in clk cycles; legal range 1..2^32-1. Used only when TICK_PRESCALER_EN is defined.
- Ports:
  - clk  in  1  sole clock; all state updates on its rising edge.
  - rst  in  1  synchronous, active-low reset.
  - en  in  1  count enable.
  - up  in  1  direction: 1 = increment, 0 = decrement.
  - load  in  1  synchronous parallel load strobe.
  - load_val  in  4*NDIGIT  value to load; digit k occupies bits [4k+3:4k].
  - clear_ovf  in  1  clears the sticky ovf flag.
  - bcd  out  4*NDIGIT  registered count value.
  - eos  out  1  end of scale in the current direction (combinational decode of bcd and up).
  - wrap  out  1  registered one-cycle pulse on a wrap event.
  - ovf  out  1  sticky out-of-range flag.

## Operation
- step = en & tick. tick is the prescaler output, or constant 1 when the prescaler is compiled out.
- Priority at each edge: reset, then load, then step.
- Load:
  - bcd <= load_val, independent of en and tick.
  - Any load digit greater than 9 is clamped to 9.
  - A load cycle produces wrap = 0 and leaves ovf unchanged.
- Up step:
  - Digit 0 increments.
  - Digit k (k>0) increments only when all lower digits equal 9.
  - A digit at 9 that steps goes to 0.
  - All digits at 9 → all 0, wrap = 1, ovf set.
- Down step:
  - Digit 0 decrements.
  - Digit k decrements only when all lower digits equal 0.
  - A digit at 0 that steps goes to 9.
  - All digits at 0 → all 9, wrap = 1, ovf set.
- The carry/borrow chain is combinational across all digits; the whole count updates in one cycle.
- eos = (up & bcd == all 9s) | (~up & bcd == all 0s).
- ovf:
  - Set on any wrap event.
  - Cleared by clear_ovf = 1.
  - If a wrap and clear_ovf occur in the same cycle, set wins.
- Changing up takes effect on the next step; no pipeline flush is needed.

## Timing
- Reset (rst = 0 at an edge) gives: bcd = 0, wrap = 0, ovf = 0, prescaler count = 0. eos then reads ~up.
- Latency:
  - bcd, wrap and ovf reflect a step or load one edge after it is sampled.
  - eos follows bcd and up with zero latency.
- wrap is high for exactly one cycle, aligned with the first cycle that shows the wrapped bcd value.
- Prescaler:
  - Free-running count 0..TICK_MAX-1; not gated by en or load.
  - tick = 1 for one cycle when count == TICK_MAX-1.
  - With TICK_MAX = 1, tick is constantly 1.
  - After reset release, the first step edge is edge number TICK_MAX.
- Reset asserted mid-count overrides load and step in that cycle and restarts the prescaler.

## Configuration
- TICK_PRESCALER_EN defined:
  - The internal prescaler is instantiated and tick follows the rules above.
  - TICK_MAX sets the step rate, e.g. 100 gives 1 MHz at a 100 MHz clk.
- TICK_PRESCALER_EN undefined:
  - No prescaler logic; tick = 1, so step = en.
  - TICK_MAX is ignored.
  - An external rate generator drives en as a one-cycle pulse.

## Structure
- Shared header bcd_defs holds BCD_DIGIT_W = 4, BCD_MAX_DIGIT = 4'd9, BCD_MIN_DIGIT = 4'd0.
- Sub-module bcd_updown_digit, one instance per digit via a generate loop:
  - Inputs: clk, rst, step, up, load, load digit.
  - Outputs: digit value, term (9 when up, 0 when down).
- The top level contains:
  - the AND-chain of term signals;
  - eos, wrap and ovf logic;
  - the optional prescaler.

## Test plan
- Reset then count (NDIGIT = 2, prescaler out, en = 1, up = 1): 10 clocks → bcd = 8'h10; 99 clocks → 8'h99 with eos = 1; next clock → 8'h00, wrap high for 1 cycle, ovf = 1.
- Down underflow (NDIGIT = 3): load 12'h001, up = 0, en = 1. Clock 1 → 12'h000 with eos = 1. Clock 2 → 12'h999, wrap = 1, ovf = 1.
- Load priority and clamp: load = 1, en = 1, load_val = 8'h3C → bcd = 8'h39, wrap = 0, ovf unchanged.
- ovf set/clear: clear_ovf in the same cycle as a wrap → ovf = 1. clear_ovf alone on the next cycle → ovf = 0.
- Prescaler (macro defined, TICK_MAX = 5, en = 1): bcd increments exactly at edges 5, 10, 15 after reset release. en = 0 at edge 10 → no increment at edge 10, next increment at edge 15.
- Mid-operation reset: rst = 0 while bcd = 8'h57 and load = 1 → bcd = 8'h00, ovf = 0, wrap = 0 on the next cycle.
